uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter: 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Bytes enter through a valid/ready handshake into a small internal FIFO and are serialised at CLKS_PER_BIT clock cycles per bit.
- Transmit-side counterpart of the peripheral UART receiver. Sits in the UART peripheral, driven by the bus-side register logic.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (clock frequency / baud rate). Legal range is >= 2.
- FIFO_DEPTH, 4, number of byte entries in the transmit FIFO. Must be a power of two and >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_byte_in  input  8  byte to transmit.
- tx_valid_in  input  1  tx_byte_in is valid.
- tx_ready_out  output  1  FIFO can accept a byte. Equals (count < FIFO_DEPTH).
- tx_serial_out  output  1  serial line. Registered. Idles high.
- tx_busy_out  output  1  high while state != IDLE or FIFO is non-empty.
- tx_done_out  output  1  one-cycle pulse, high exactly during the CLEANUP state.
- tx_fifo_count_out  output  $clog2(FIFO_DEPTH+1)  number of bytes held in the FIFO.

Behaviour:
- Reset values: tx_serial_out=1, tx_ready_out=1, tx_busy_out=0, tx_done_out=0, tx_fifo_count_out=0.
- Reset also clears the FIFO read/write pointers, the bit counter and the clock counter, and puts the FSM in IDLE.
- Reset mid-frame:
  - the frame is aborted;
  - the line is high in the cycle after rst is sampled;
  - no done pulse is produced;
  - all queued bytes are discarded.
- Push: occurs on a cycle where tx_valid_in && tx_ready_out. The byte is written at the write pointer.
  - tx_valid_in while full is ignored; the sender must hold the byte.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop: occurs only in IDLE with count != 0. The head byte is copied into the shift register.
  - Push and pop in the same cycle leave count unchanged.
  - A byte pushed into an empty FIFO cannot pop in the same cycle. Its earliest pop is the following cycle.
- FSM states: IDLE, START_BIT, SEND_DATA, SEND_STOP_BIT, CLEANUP.
  - IDLE: line=1. If count != 0: pop, clk_count<=CLKS_PER_BIT-1, go to START_BIT.
  - START_BIT: line=0.
    - At clk_count==0: clk_count<=CLKS_PER_BIT-1, bit_idx<=0, go to SEND_DATA.
    - Otherwise decrement clk_count.
  - SEND_DATA: line = shift_reg[0].
    - At clk_count==0: shift right, reload clk_count.
    - If bit_idx==7, go to SEND_STOP_BIT. Otherwise bit_idx+1.
  - SEND_STOP_BIT: line=1. At clk_count==0, go to CLEANUP.
  - CLEANUP: line=1, tx_done_out=1 for one cycle, then IDLE unconditionally.
- Line register timing: tx_serial_out is updated on the same edge as the state change. Each start, data and stop bit is therefore driven for exactly CLKS_PER_BIT cycles.
- Frame timing:
  - Latency from a push into an empty idle block to the first low cycle on tx_serial_out is 2 cycles (push edge, pop edge).
  - One frame occupies 10*CLKS_PER_BIT line cycles, followed by 1 CLEANUP cycle.
  - Back-to-back frames: the line stays high for CLKS_PER_BIT+2 cycles between the last data bit and the next start bit (stop bit + CLEANUP + IDLE).
- tx_fifo_count_out and tx_ready_out are combinational from the pointers/count register. tx_ready_out falls in the cycle after the push that fills the FIFO.
- Unreachable state encodings go to IDLE with line=1.

Test Plan:
- Reset with CLKS_PER_BIT=4. Hold rst for 2 cycles and release.
  - Required: line=1, ready=1, busy=0, count=0, done=0. The line stays 1 for 20 idle cycles.
- Push 0xA5 once.
  - Required: after 2 cycles, line shows 0 | 1,0,1,0,0,1,0,1 | 1, each bit for exactly 4 cycles.
  - done pulses for 1 cycle at cycle 2+40. busy falls afterwards.
- Push 0x00, 0xFF, 0x3C, 0x81 on consecutive cycles (FIFO_DEPTH=4).
  - Required: ready stays 1 throughout, because the first pop (cycle after the first push) frees a slot before the fourth push. Count never exceeds 3.
  - The four frames appear in order, separated by 6 high cycles.
  - Exactly four done pulses. count returns to 0.
- Fill the FIFO during a frame, then hold valid with byte 0x55.
  - Required: ready=0 and 0x55 is not accepted until the next pop. 0x55 is sent exactly once, after the queued bytes.
- Assert rst for 1 cycle midway through SEND_DATA with 2 bytes queued.
  - Required: line=1 next cycle, count=0, no done pulse, no further frames.
- Push and pop in the same cycle (push while IDLE with count=1).
  - Required: count stays 1. Bytes are transmitted in FIFO order.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a valid/ready byte FIFO; ports clk, rst, tx_byte_in/tx_valid_in/tx_ready_out push handshake, tx_serial_out line (idles high), tx_busy_out, tx_done_out (CLEANUP pulse), tx_fifo_count_out
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         tx_byte_in,
    input  logic                               tx_valid_in,
    output logic                               tx_ready_out,
    output logic                               tx_serial_out,
    output logic                               tx_busy_out,
    output logic                               tx_done_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    tx_fifo_count_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int KW = $clog2(CLKS_PER_BIT);
    localparam logic [KW-1:0] K_MAX = KW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {IDLE, START_BIT, SEND_DATA, SEND_STOP_BIT, CLEANUP} state_t;
    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [KW-1:0] clk_count;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          push, pop;
    assign tx_ready_out      = count < CW'(FIFO_DEPTH);
    assign tx_fifo_count_out = count;
    assign tx_busy_out       = state != IDLE || count != '0;
    assign push              = tx_valid_in && tx_ready_out;
    assign pop               = state == IDLE && count != '0;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= tx_byte_in;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // the line register is loaded with the level of the state being entered,
    // so every bit is on the wire for exactly CLKS_PER_BIT cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            tx_serial_out <= 1'b1;
            tx_done_out   <= 1'b0;
            clk_count     <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
        end else begin
            tx_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial_out <= 1'b1;
                    if (pop) begin
                        shift_reg     <= mem[rd_ptr];
                        clk_count     <= K_MAX;
                        tx_serial_out <= 1'b0;
                        state         <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (clk_count == '0) begin
                        clk_count     <= K_MAX;
                        bit_idx       <= '0;
                        tx_serial_out <= shift_reg[0];
                        state         <= SEND_DATA;
                    end else begin
                        clk_count <= clk_count - 1'b1;
                    end
                end
                SEND_DATA: begin
                    if (clk_count == '0) begin
                        clk_count <= K_MAX;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == 3'd7) begin
                            tx_serial_out <= 1'b1;
                            state         <= SEND_STOP_BIT;
                        end else begin
                            bit_idx       <= bit_idx + 1'b1;
                            tx_serial_out <= shift_reg[1];
                        end
                    end else begin
                        clk_count <= clk_count - 1'b1;
                    end
                end
                SEND_STOP_BIT: begin
                    tx_serial_out <= 1'b1;
                    if (clk_count == '0) begin
                        tx_done_out <= 1'b1;
                        state       <= CLEANUP;
                    end else begin
                        clk_count <= clk_count - 1'b1;
                    end
                end
                CLEANUP: begin
                    tx_serial_out <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    tx_serial_out <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       valid = 1'b0;
    logic       ready, line, busy, done;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .tx_byte_in(tx_byte),
        .tx_valid_in(valid),
        .tx_ready_out(ready),
        .tx_serial_out(line),
        .tx_busy_out(busy),
        .tx_done_out(done),
        .tx_fifo_count_out(count)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (done === 1'b1) done_cnt++;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    // checks frame samples start..39 from the current negedge, then the CLEANUP sample
    task automatic frame(input logic [7:0] b, input int start);
        logic e;
        for (int i = start; i < 40; i++) begin
            e = (i < 4) ? 1'b0 : (i < 36) ? b[(i-4)/4] : 1'b1;
            chk($sformatf("line[%02h:%0d]", b, i), 32'(line), 32'(e));
            chk("done_in_frame", 32'(done), 0);
            tick();
        end
        chk("done_pulse", 32'(done), 1);
        chk("line_cleanup", 32'(line), 1);
    endtask
    task automatic next_frame(input logic [7:0] b);
        tick();
        chk("line_idle_gap", 32'(line), 1);
        chk("done_idle_gap", 32'(done), 0);
        tick();
        frame(b, 0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        tick();
        rst = 1'b0;
        chk("rst_line", 32'(line), 1);
        chk("rst_ready", 32'(ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_done", 32'(done), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_line", 32'(line), 1);
        end
        valid = 1'b1; tx_byte = 8'hA5;
        tick();
        valid = 1'b0;
        chk("a5_line_push", 32'(line), 1);
        chk("a5_count", 32'(count), 1);
        chk("a5_busy", 32'(busy), 1);
        tick();
        frame(8'hA5, 0);
        tick();
        chk("a5_busy_after", 32'(busy), 0);
        chk("a5_done_after", 32'(done), 0);
        chk("a5_done_cnt", 32'(done_cnt), 1);
        valid = 1'b1; tx_byte = 8'h00;
        chk("b2b_ready0", 32'(ready), 1);
        tick();
        chk("b2b_count1", 32'(count), 1);
        chk("b2b_ready1", 32'(ready), 1);
        tx_byte = 8'hFF;
        tick();
        chk("b2b_count2", 32'(count), 1);
        chk("b2b_ready2", 32'(ready), 1);
        chk("b2b_start", 32'(line), 0);
        tx_byte = 8'h3C;
        tick();
        chk("b2b_count3", 32'(count), 2);
        chk("b2b_ready3", 32'(ready), 1);
        tx_byte = 8'h81;
        tick();
        chk("b2b_count4", 32'(count), 3);
        valid = 1'b0;
        tick();
        frame(8'h00, 3);
        next_frame(8'hFF);
        next_frame(8'h3C);
        next_frame(8'h81);
        tick();
        chk("b2b_busy_end", 32'(busy), 0);
        chk("b2b_count_end", 32'(count), 0);
        chk("b2b_done_cnt", 32'(done_cnt), 5);
        valid = 1'b1; tx_byte = 8'h11;
        tick();
        tx_byte = 8'h22;
        tick();
        tx_byte = 8'h33;
        tick();
        tx_byte = 8'h44;
        tick();
        tx_byte = 8'h66;
        tick();
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(ready), 0);
        tx_byte = 8'h55;
        frame(8'h11, 3);
        chk("full_count_cleanup", 32'(count), 4);
        chk("full_ready_cleanup", 32'(ready), 0);
        tick();
        chk("full_count_idle", 32'(count), 4);
        chk("full_ready_idle", 32'(ready), 0);
        chk("full_line_idle", 32'(line), 1);
        tick();
        chk("full_count_pop", 32'(count), 3);
        chk("full_ready_pop", 32'(ready), 1);
        chk("full_line_pop", 32'(line), 0);
        tick();
        chk("full_count_55", 32'(count), 4);
        valid = 1'b0;
        frame(8'h22, 1);
        next_frame(8'h33);
        next_frame(8'h44);
        next_frame(8'h66);
        next_frame(8'h55);
        tick();
        chk("full_busy_end", 32'(busy), 0);
        chk("full_count_end", 32'(count), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("full_no_extra", 32'(line), 1);
        end
        chk("full_done_cnt", 32'(done_cnt), 11);
        valid = 1'b1; tx_byte = 8'hA1;
        tick();
        tx_byte = 8'hB2;
        tick();
        tx_byte = 8'hC3;
        tick();
        valid = 1'b0;
        chk("rstm_count", 32'(count), 2);
        repeat (11) tick();
        chk("rstm_data_bit2", 32'(line), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_line", 32'(line), 1);
        chk("rstm_count", 32'(count), 0);
        chk("rstm_busy", 32'(busy), 0);
        chk("rstm_ready", 32'(ready), 1);
        chk("rstm_done", 32'(done), 0);
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("rstm_quiet_line", 32'(line), 1);
            chk("rstm_quiet_busy", 32'(busy), 0);
        end
        chk("rstm_done_cnt", 32'(done_cnt), 11);
        valid = 1'b1; tx_byte = 8'hD4;
        tick();
        chk("pp_count_a", 32'(count), 1);
        tx_byte = 8'hE5;
        tick();
        chk("pp_count_b", 32'(count), 1);
        valid = 1'b0;
        frame(8'hD4, 0);
        next_frame(8'hE5);
        tick();
        chk("pp_count_end", 32'(count), 0);
        chk("pp_busy_end", 32'(busy), 0);
        chk("pp_done_cnt", 32'(done_cnt), 13);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
